// File: rtl/spi_regbank_slave_pkg.sv
// Shared types and elaboration helpers for the SPI register-bank slave.
package spi_regbank_slave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   // W is shifted in first, so it ends up just above the address bits
   function automatic int cmd_w_pos(input int addr_w);
      return addr_w;
   endfunction

   function automatic int addr_w_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Modes 0 and 3 sample on rising ck, modes 1 and 2 on falling
   function automatic bit sample_on_rise(input int cpol, input int cpha);
      return cpol == cpha;
   endfunction

endpackage

// File: rtl/spi_regbank_slave_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on its last two stages.
module sync_edge #(
   parameter int   SYNC_STG = 3,
   parameter logic RST_VAL  = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_STG-1:0] stg_q;
   logic [SYNC_STG-1:0] stg_d;

   always_comb stg_d = {stg_q[SYNC_STG-2:0], d};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stg_q <= {SYNC_STG{RST_VAL}};
      else     stg_q <= stg_d;
   end

   assign sync = stg_q[SYNC_STG-1];
   assign rise = stg_q[SYNC_STG-2] & ~stg_q[SYNC_STG-1];
   assign fall = ~stg_q[SYNC_STG-2] & stg_q[SYNC_STG-1];

endmodule

// File: rtl/spi_regbank_slave.sv
// SPI slave exposing a NUM_REGS x DATA_W register bank with burst R/W access.
module spi_regbank_slave
   import spi_regbank_slave_pkg::*;
#(
   parameter int               DATA_W    = 8,
   parameter int               NUM_REGS  = 4,
   parameter int               CPOL      = 0,
   parameter int               CPHA      = 0,
   parameter int               SYNC_STG  = 3,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   localparam int              ADDR_W    = addr_w_of(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cs,
   input  logic                       ck,
   input  logic                       mo,
   output logic                       mi,
   output logic                       en,
   output logic [NUM_REGS*DATA_W-1:0] regs,
   output logic                       wr_stb,
   output logic [ADDR_W-1:0]          wr_idx,
   output logic                       rd_stb
);

   localparam int CMD_W = 1 + ADDR_W;
   localparam int SH_W  = max_of(DATA_W, CMD_W);
   localparam int CNT_W = $clog2(SH_W + 1);
   localparam int W_POS = cmd_w_pos(ADDR_W);
   localparam bit SMP_RISE = sample_on_rise(CPOL, CPHA);
   localparam logic [CNT_W-1:0]  CMD_END  = CNT_W'(CMD_W);
   localparam logic [CNT_W-1:0]  WORD_END = CNT_W'(DATA_W);
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_REGS - 1);

   logic cs_s, cs_r, cs_f;
   logic ck_s, ck_r, ck_f;
   logic mo_s, mo_r, mo_f;
   logic smp, drv;
   logic unused_sync;

   sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_cs (
      .clk(clk), .rst(rst), .d(cs),
      .sync(cs_s), .rise(cs_r), .fall(cs_f)
   );
   sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'(CPOL))) u_ck (
      .clk(clk), .rst(rst), .d(ck),
      .sync(ck_s), .rise(ck_r), .fall(ck_f)
   );
   sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_mo (
      .clk(clk), .rst(rst), .d(mo),
      .sync(mo_s), .rise(mo_r), .fall(mo_f)
   );

   assign unused_sync = ^{ck_s, mo_r, mo_f};
   assign smp = SMP_RISE ? ck_r : ck_f;
   assign drv = SMP_RISE ? ck_f : ck_r;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nx;
   logic [SH_W-1:0]     sin_q, sin_d, sin_nx;
   logic [DATA_W-1:0]   sout_q, sout_d;
   logic                w_q, w_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d, nptr, cmd_ptr;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic                wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
   logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sin_d    = sin_q;
      sout_d   = sout_q;
      w_d      = w_q;
      ptr_d    = ptr_q;
      regs_d   = regs_q;
      wr_stb_d = 1'b0;
      rd_stb_d = 1'b0;
      wr_idx_d = wr_idx_q;
      sin_nx   = {sin_q[SH_W-2:0], mo_s};
      cnt_nx   = cnt_q + 1'b1;
      nptr     = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
      cmd_ptr  = (int'(sin_nx[ADDR_W-1:0]) >= NUM_REGS) ? '0 : sin_nx[ADDR_W-1:0];
      unique case (state_q)
         ST_IDLE: begin
            if (cs_f) begin
               state_d = ST_CMD;
               cnt_d   = '0;
               sin_d   = '0;
            end
         end
         ST_CMD: begin
            if (smp) begin
               sin_d = sin_nx;
               cnt_d = cnt_nx;
               if (cnt_nx == CMD_END) begin
                  w_d      = sin_nx[W_POS];
                  ptr_d    = cmd_ptr;
                  sout_d   = regs_q[cmd_ptr];
                  rd_stb_d = ~sin_nx[W_POS];
                  cnt_d    = '0;
                  state_d  = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (smp) begin
               sin_d = sin_nx;
               cnt_d = cnt_nx;
               if (cnt_nx == WORD_END) begin
                  cnt_d  = '0;
                  ptr_d  = nptr;
                  sout_d = regs_q[nptr];
                  if (w_q) begin
                     regs_d[ptr_q] = sin_nx[DATA_W-1:0];
                     wr_stb_d      = 1'b1;
                     wr_idx_d      = ptr_q;
                  end else begin
                     rd_stb_d = 1'b1;
                  end
               end
            // The first drive edge of a word must keep the freshly loaded MSB
            end else if (drv && cnt_q != '0) begin
               sout_d = {sout_q[DATA_W-2:0], 1'b1};
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (cs_r && state_q != ST_IDLE) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sin_q    <= '0;
         sout_q   <= '1;
         w_q      <= 1'b0;
         ptr_q    <= '0;
         wr_stb_q <= 1'b0;
         rd_stb_q <= 1'b0;
         wr_idx_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sin_q    <= sin_d;
         sout_q   <= sout_d;
         w_q      <= w_d;
         ptr_q    <= ptr_d;
         wr_stb_q <= wr_stb_d;
         rd_stb_q <= rd_stb_d;
         wr_idx_q <= wr_idx_d;
         regs_q   <= regs_d;
      end
   end

   always_comb begin
      regs = '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i*DATA_W +: DATA_W] = regs_q[i];
   end

   assign mi     = (state_q == ST_DATA) ? sout_q[DATA_W-1] : 1'b1;
   assign en     = ~cs_s;
   assign wr_stb = wr_stb_q;
   assign wr_idx = wr_idx_q;
   assign rd_stb = rd_stb_q;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Directed bench: mode 0 / 8-bit and mode 3 / 16-bit register banks.
module tb_spi_regbank_slave;

   localparam int HALF = 80;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs0, ck0, cs1, ck1, mo;
   logic        mi0, en0, wr_stb0, rd_stb0;
   logic        mi1, en1, wr_stb1, rd_stb1;
   logic [31:0] regs0;
   logic [63:0] regs1;
   logic [1:0]  wr_idx0, wr_idx1;

   int n_cmp = 0;
   int n_bad = 0;
   int wrc [2] = '{0, 0};
   int rdc [2] = '{0, 0};
   logic [1:0] lastw [2] = '{2'd0, 2'd0};

   spi_regbank_slave #(.DATA_W(8)) u0 (
      .clk(clk), .rst(rst), .cs(cs0), .ck(ck0), .mo(mo),
      .mi(mi0), .en(en0), .regs(regs0),
      .wr_stb(wr_stb0), .wr_idx(wr_idx0), .rd_stb(rd_stb0)
   );

   spi_regbank_slave #(.DATA_W(16), .CPOL(1), .CPHA(1)) u1 (
      .clk(clk), .rst(rst), .cs(cs1), .ck(ck1), .mo(mo),
      .mi(mi1), .en(en1), .regs(regs1),
      .wr_stb(wr_stb1), .wr_idx(wr_idx1), .rd_stb(rd_stb1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_stb0) begin wrc[0] <= wrc[0] + 1; lastw[0] <= wr_idx0; end
      if (wr_stb1) begin wrc[1] <= wrc[1] + 1; lastw[1] <= wr_idx1; end
      if (rd_stb0) rdc[0] <= rdc[0] + 1;
      if (rd_stb1) rdc[1] <= rdc[1] + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] reg_of(input int sel, input int idx);
      if (sel == 1) return regs1[idx*16 +: 16];
      return {8'h00, regs0[idx*8 +: 8]};
   endfunction

   function automatic logic mi_of(input int sel);
      return (sel == 1) ? mi1 : mi0;
   endfunction

   task automatic tog(input int sel);
      if (sel == 1) ck1 = ~ck1;
      else          ck0 = ~ck0;
   endtask

   task automatic set_cs(input int sel, input logic v);
      if (sel == 1) cs1 = v;
      else          cs0 = v;
   endtask

   // sel 0: CPHA=0 (sample leading), sel 1: CPHA=1 (sample trailing)
   task automatic xfer(input int sel, input int n, input logic [63:0] bits,
                       input bit coinc, output logic [63:0] got);
      got = '0;
      set_cs(sel, 1'b0);
      #HALF;
      for (int i = n - 1; i >= 0; i--) begin
         if (sel == 0) begin
            mo = bits[i];
            #HALF;
            tog(sel);
            got[i] = mi_of(sel);
            #HALF;
            tog(sel);
         end else begin
            tog(sel);
            mo = bits[i];
            #HALF;
            tog(sel);
            if (coinc && i == 0) set_cs(sel, 1'b1);
            got[i] = mi_of(sel);
            #HALF;
         end
      end
      #HALF;
      set_cs(sel, 1'b1);
      #(2 * HALF);
   endtask

   typedef struct {
      int          sel;
      int          n;
      logic [63:0] bits;
      logic [63:0] mi_exp;
      int          ra;
      logic [15:0] va;
      int          rb;
      logic [15:0] vb;
      int          dwr;
      int          widx;
      int          drd;
   } vec_t;

   vec_t        tbl [8];
   logic [63:0] got;
   int          w_b, r_b;

   initial begin
      tbl[0] = '{0, 11, 64'({3'b110, 8'hA5}), 64'({3'b111, 8'h00}),
                 2, 16'h00A5, 0, 16'h0000, 1, 2, 0};
      tbl[1] = '{0, 11, 64'({3'b010, 8'h00}), 64'({3'b111, 8'hA5}),
                 2, 16'h00A5, 3, 16'h0000, 0, 0, 2};
      tbl[2] = '{0, 19, 64'({3'b111, 8'h11, 8'h22}), 64'({3'b111, 8'h00, 8'h00}),
                 3, 16'h0011, 0, 16'h0022, 2, 0, 0};
      tbl[3] = '{0, 19, 64'({3'b011, 8'h00, 8'h00}), 64'({3'b111, 8'h11, 8'h22}),
                 3, 16'h0011, 0, 16'h0022, 0, 0, 3};
      tbl[4] = '{0, 11, 64'({3'b100, 8'h5A}), 64'({3'b111, 8'h22}),
                 0, 16'h005A, 2, 16'h00A5, 1, 0, 0};
      tbl[5] = '{0, 8, 64'({3'b101, 5'b10110}), 64'({3'b111, 5'b00000}),
                 1, 16'h0000, 0, 16'h005A, 0, 0, 0};
      tbl[6] = '{1, 19, 64'({3'b110, 16'hBEEF}), 64'({3'b111, 16'h0000}),
                 2, 16'hBEEF, 0, 16'h0000, 1, 2, 0};
      tbl[7] = '{1, 19, 64'({3'b010, 16'h0000}), 64'({3'b111, 16'hBEEF}),
                 2, 16'hBEEF, 3, 16'h0000, 0, 0, 2};

      rst = 1'b1;
      cs0 = 1'b1; ck0 = 1'b0;
      cs1 = 1'b1; ck1 = 1'b1;
      mo  = 1'b0;
      #1;
      chk("rst mi0", 64'(mi0), 64'd1);
      chk("rst en0", 64'(en0), 64'd0);
      chk("rst regs0", 64'(regs0), 64'd0);
      chk("rst strobes0", 64'({wr_stb0, rd_stb0, wr_idx0}), 64'd0);
      chk("rst mi1", 64'(mi1), 64'd1);
      chk("rst regs1", regs1, 64'd0);
      #40;
      rst = 1'b0;
      #(2 * HALF);

      for (int i = 0; i < 16; i++) begin
         mo = 1'($urandom_range(1));
         tog(0);
         tog(1);
         #HALF;
      end
      chk("idle ck regs0", 64'(regs0), 64'd0);
      chk("idle ck regs1", regs1, 64'd0);
      chk("idle ck strobes", 64'(wrc[0] + rdc[0] + wrc[1] + rdc[1]), 64'd0);
      chk("idle ck mi/en", 64'({mi0, en0, mi1, en1}), 64'b1010);

      cs0 = 1'b0;
      #(2 * HALF);
      chk("cs only en", 64'(en0), 64'd1);
      chk("cs only mi", 64'(mi0), 64'd1);
      cs0 = 1'b1;
      #(2 * HALF);
      chk("cs only en off", 64'(en0), 64'd0);
      chk("cs only regs", 64'(regs0), 64'd0);
      chk("cs only strobes", 64'(wrc[0] + rdc[0]), 64'd0);

      for (int k = 0; k < 8; k++) begin
         w_b = wrc[tbl[k].sel];
         r_b = rdc[tbl[k].sel];
         xfer(tbl[k].sel, tbl[k].n, tbl[k].bits, 1'b0, got);
         chk($sformatf("v%0d mi", k), got, tbl[k].mi_exp);
         chk($sformatf("v%0d reg%0d", k, tbl[k].ra),
             64'(reg_of(tbl[k].sel, tbl[k].ra)), 64'(tbl[k].va));
         chk($sformatf("v%0d reg%0d", k, tbl[k].rb),
             64'(reg_of(tbl[k].sel, tbl[k].rb)), 64'(tbl[k].vb));
         chk($sformatf("v%0d wr_stb count", k),
             64'(wrc[tbl[k].sel] - w_b), 64'(tbl[k].dwr));
         chk($sformatf("v%0d rd_stb count", k),
             64'(rdc[tbl[k].sel] - r_b), 64'(tbl[k].drd));
         if (tbl[k].dwr > 0)
            chk($sformatf("v%0d wr_idx", k),
                64'(lastw[tbl[k].sel]), 64'(tbl[k].widx));
      end

      // cs rises on the same instant as the last trailing (sample) edge
      w_b = wrc[1];
      xfer(1, 19, 64'({3'b101, 16'h1234}), 1'b1, got);
      chk("coinc reg1", 64'(reg_of(1, 1)), 64'h1234);
      chk("coinc wr count", 64'(wrc[1] - w_b), 64'd1);
      chk("coinc wr_idx", 64'(lastw[1]), 64'd1);
      chk("coinc mi idle", 64'(mi1), 64'd1);

      cs0 = 1'b0;
      #HALF;
      mo = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tog(0);
         #HALF;
      end
      rst = 1'b1;
      #1;
      chk("midrst regs0", 64'(regs0), 64'd0);
      chk("midrst regs1", regs1, 64'd0);
      chk("midrst mi0/en0", 64'({mi0, en0}), 64'b10);
      cs0 = 1'b1;
      ck0 = 1'b0;
      #40;
      rst = 1'b0;
      #(2 * HALF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
